// File: rtl/common.sv
// Shared types for the input-filtering blocks.
// filter_mode_t selects symmetric or fast-assert debouncing.
package common;

    typedef enum logic {
        FILTER_SYMMETRIC   = 1'b0,
        FILTER_FAST_ASSERT = 1'b1
    } filter_mode_t;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, run counter, filtered level, edge pulses.
// Ports: clk28, rst_n (async low), clk_en strobe, d raw in; q level, rise/fall pulses, cnt_nz.
module debounce_ch
    import common::*;
#(
    parameter int unsigned  CNT_W         = 3,
    parameter int unsigned  THRESH        = 7,
    parameter logic         DEFAULT_STATE = 1'b1,
    parameter filter_mode_t MODE          = FILTER_SYMMETRIC
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic clk_en,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic cnt_nz
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        if (sync2_q == q_q) begin
            cnt_d = '0;
        end else if (MODE == FILTER_FAST_ASSERT &&
                     sync2_q == ~DEFAULT_STATE) begin
            // s differs from q and is the active level, so q is idle:
            // the active edge bypasses the filter.
            q_d   = sync2_q;
            cnt_d = '0;
        end else if (clk_en) begin
            if (cnt_q == LAST) begin
                q_d   = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= DEFAULT_STATE;
            sync2_q <= DEFAULT_STATE;
            cnt_q   <= '0;
            q_q     <= DEFAULT_STATE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q      = q_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign cnt_nz = |cnt_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels plus a shared busy flag.
// Ports: clk28, rst_n, clk_en, d[CHANNELS]; q/rise/fall[CHANNELS], busy.
module debounce_bank
    import common::*;
#(
    parameter int unsigned  CHANNELS      = 8,
    parameter int unsigned  CNT_W         = 3,
    parameter int unsigned  THRESH        = 7,
    parameter logic         DEFAULT_STATE = 1'b1,
    parameter filter_mode_t MODE          = FILTER_SYMMETRIC
) (
    input  logic                clk28,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [CHANNELS-1:0] d,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                busy
);

    logic [CHANNELS-1:0] cnt_nz;
    logic                busy_q, busy_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_ch #(
            .CNT_W        (CNT_W),
            .THRESH       (THRESH),
            .DEFAULT_STATE(DEFAULT_STATE),
            .MODE         (MODE)
        ) u_ch (
            .clk28 (clk28),
            .rst_n (rst_n),
            .clk_en(clk_en),
            .d     (d[i]),
            .q     (q[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .cnt_nz(cnt_nz[i])
        );
    end

    always_comb begin
        busy_d = |cnt_nz;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: symmetric and fast-assert instances.
// Directed scenarios plus random bursts against a behavioural model.
module tb_debounce_bank;
    import common::*;

    localparam int TH = 7;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [3:0] d;

    logic [3:0] q_s, rise_s, fall_s;
    logic       busy_s;
    logic [3:0] q_f, rise_f, fall_f;
    logic       busy_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk28 = ~clk28;

    debounce_bank #(
        .CHANNELS(4), .CNT_W(3), .THRESH(TH),
        .DEFAULT_STATE(1'b1), .MODE(FILTER_SYMMETRIC)
    ) dut_s (
        .clk28(clk28), .rst_n(rst_n), .clk_en(clk_en), .d(d),
        .q(q_s), .rise(rise_s), .fall(fall_s), .busy(busy_s)
    );

    debounce_bank #(
        .CHANNELS(4), .CNT_W(3), .THRESH(TH),
        .DEFAULT_STATE(1'b1), .MODE(FILTER_FAST_ASSERT)
    ) dut_f (
        .clk28(clk28), .rst_n(rst_n), .clk_en(clk_en), .d(d),
        .q(q_f), .rise(rise_f), .fall(fall_f), .busy(busy_f)
    );

    // Behavioural model: index 0 = symmetric, 1 = fast-assert.
    // run[m][c] counts enabled samples seen while s disagrees with q.
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_q[2];
    logic [3:0] m_rise[2];
    logic [3:0] m_fall[2];
    logic       m_busy[2];
    int         run[2][4];

    function automatic logic nxt_q(int m, logic s, logic qv,
                                   int r, logic en);
        if (s == qv) return qv;
        if (m == 1 && s == 1'b0) return s;
        if (en && r + 1 >= TH) return s;
        return qv;
    endfunction

    function automatic int nxt_run(int m, logic s, logic qv,
                                   int r, logic en);
        if (s == qv) return 0;
        if (m == 1 && s == 1'b0) return 0;
        if (!en) return r;
        if (r + 1 >= TH) return 0;
        return r + 1;
    endfunction

    function automatic logic any_run(int m);
        for (int c = 0; c < 4; c++)
            if (run[m][c] != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 4'hF;
            m_s2 <= 4'hF;
            for (int m = 0; m < 2; m++) begin
                m_q[m]    <= 4'hF;
                m_rise[m] <= 4'h0;
                m_fall[m] <= 4'h0;
                m_busy[m] <= 1'b0;
                for (int c = 0; c < 4; c++) run[m][c] <= 0;
            end
        end else begin
            m_s1 <= d;
            m_s2 <= m_s1;
            for (int m = 0; m < 2; m++) begin
                m_busy[m] <= any_run(m);
                for (int c = 0; c < 4; c++) begin
                    m_q[m][c] <= nxt_q(m, m_s2[c], m_q[m][c],
                                       run[m][c], clk_en);
                    run[m][c] <= nxt_run(m, m_s2[c], m_q[m][c],
                                         run[m][c], clk_en);
                    m_rise[m][c] <= nxt_q(m, m_s2[c], m_q[m][c],
                                          run[m][c], clk_en)
                                    & ~m_q[m][c];
                    m_fall[m][c] <= ~nxt_q(m, m_s2[c], m_q[m][c],
                                           run[m][c], clk_en)
                                    & m_q[m][c];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic settle(int n);
        d      = 4'hF;
        clk_en = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        d      = 4'h0;
        clk_en = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({q_s, rise_s, fall_s, busy_s} !== 13'h1E00) begin
            n_err++;
            $display("FAIL reset_sym: got %h want 1e00",
                     {q_s, rise_s, fall_s, busy_s});
        end
        n_cmp++;
        if ({q_f, rise_f, fall_f, busy_f} !== 13'h1E00) begin
            n_err++;
            $display("FAIL reset_fast: got %h want 1e00",
                     {q_f, rise_f, fall_f, busy_f});
        end
        d = 4'hF;
        tick();
        rst_n = 1'b1;
        settle(15);
    endtask

    task automatic test_latency();
        settle(15);
        d[0] = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (busy_s !== 1'b1) begin
            n_err++;
            $display("FAIL lat_busy: got %b want 1", busy_s);
        end
        repeat (3) tick();
        n_cmp++;
        if (q_s !== 4'hF || fall_s !== 4'h0) begin
            n_err++;
            $display("FAIL lat_early: q %h fall %h want f 0",
                     q_s, fall_s);
        end
        tick();
        n_cmp++;
        if (q_s !== 4'hE || fall_s !== 4'h1 || rise_s !== 4'h0) begin
            n_err++;
            $display("FAIL lat_edge9: q %h fall %h rise %h want e 1 0",
                     q_s, fall_s, rise_s);
        end
        tick();
        n_cmp++;
        if (fall_s !== 4'h0) begin
            n_err++;
            $display("FAIL lat_pulse_end: fall %h want 0", fall_s);
        end
        tick();
        n_cmp++;
        if (busy_s !== 1'b0) begin
            n_err++;
            $display("FAIL lat_busy_clr: got %b want 0", busy_s);
        end
    endtask

    task automatic test_glitch();
        settle(15);
        d[1] = 1'b0;
        repeat (5) tick();
        d[1] = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            n_cmp++;
            if (q_s !== 4'hF || (rise_s | fall_s) !== 4'h0) begin
                n_err++;
                $display("FAIL glitch_t%0d: q %h rise %h fall %h",
                         t, q_s, rise_s, fall_s);
            end
        end
        n_cmp++;
        if (busy_s !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy: got %b want 0", busy_s);
        end
    endtask

    task automatic test_strobe();
        int  seen;
        bit  fell;
        settle(15);
        seen = 0;
        fell = 0;
        d[2] = 1'b0;
        for (int t = 1; t <= 80 && !fell; t++) begin
            clk_en = (t % 4 == 0);
            tick();
            if (t >= 3 && clk_en) seen++;
            if (q_s[2] == 1'b0) fell = 1;
            n_cmp++;
            if (q_s !== m_q[0] || busy_s !== m_busy[0]) begin
                n_err++;
                $display("FAIL strobe_t%0d: q %h busy %b want %h %b",
                         t, q_s, busy_s, m_q[0], m_busy[0]);
            end
        end
        n_cmp++;
        if (!fell) begin
            n_err++;
            $display("FAIL strobe_timeout: q2 %b want 0", q_s[2]);
        end else if (seen != TH) begin
            n_err++;
            $display("FAIL strobe_count: %0d samples want %0d",
                     seen, TH);
        end
        settle(15);
    endtask

    task automatic test_fast();
        int rises;
        int first;
        settle(15);
        d[0] = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (q_f[0] !== 1'b1) begin
            n_err++;
            $display("FAIL fast_early: q0 %b want 1", q_f[0]);
        end
        tick();
        n_cmp++;
        if (q_f !== 4'hE || fall_f !== 4'h1) begin
            n_err++;
            $display("FAIL fast_assert: q %h fall %h want e 1",
                     q_f, fall_f);
        end
        repeat (2) tick();
        d[0]  = 1'b1;
        rises = 0;
        first = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (rise_f[0]) rises++;
            if (q_f[0] && first == 0) first = t;
        end
        n_cmp++;
        if (first != 9) begin
            n_err++;
            $display("FAIL fast_release: at %0d want 9", first);
        end
        n_cmp++;
        if (rises != 1) begin
            n_err++;
            $display("FAIL fast_rise_cnt: got %0d want 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        settle(15);
        d[3] = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        d[3]  = 1'b1;
        #1;
        n_cmp++;
        if ({q_s, rise_s, fall_s, busy_s} !== 13'h1E00) begin
            n_err++;
            $display("FAIL rmid_in_reset: got %h want 1e00",
                     {q_s, rise_s, fall_s, busy_s});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_cmp++;
            if ({q_s, rise_s, fall_s, busy_s} !== 13'h1E00) begin
                n_err++;
                $display("FAIL rmid_t%0d: got %h want 1e00",
                         t, {q_s, rise_s, fall_s, busy_s});
            end
        end
    endtask

    task automatic test_simultaneous();
        settle(15);
        d = 4'h0;
        repeat (3) tick();
        n_cmp++;
        if (fall_f !== 4'hF || q_f !== 4'h0) begin
            n_err++;
            $display("FAIL simul_fast: fall %h q %h want f 0",
                     fall_f, q_f);
        end
        repeat (5) tick();
        n_cmp++;
        if (fall_s !== 4'h0) begin
            n_err++;
            $display("FAIL simul_early: fall %h want 0", fall_s);
        end
        tick();
        n_cmp++;
        if (fall_s !== 4'hF || q_s !== 4'h0) begin
            n_err++;
            $display("FAIL simul_edge: fall %h q %h want f 0",
                     fall_s, q_s);
        end
        tick();
        n_cmp++;
        if (fall_s !== 4'h0) begin
            n_err++;
            $display("FAIL simul_end: fall %h want 0", fall_s);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int k = 0; k < 200; k++) begin
            d    = d ^ 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 16);
            for (int t = 0; t < hold; t++) begin
                clk_en = ($urandom_range(0, 3) != 0);
                tick();
                n_cmp++;
                if ({q_s, rise_s, fall_s, busy_s} !==
                    {m_q[0], m_rise[0], m_fall[0], m_busy[0]}) begin
                    n_err++;
                    $display("FAIL rand_sym k%0d: got %h want %h", k,
                             {q_s, rise_s, fall_s, busy_s},
                             {m_q[0], m_rise[0], m_fall[0], m_busy[0]});
                end
                n_cmp++;
                if ({q_f, rise_f, fall_f, busy_f} !==
                    {m_q[1], m_rise[1], m_fall[1], m_busy[1]}) begin
                    n_err++;
                    $display("FAIL rand_fast k%0d: got %h want %h", k,
                             {q_f, rise_f, fall_f, busy_f},
                             {m_q[1], m_rise[1], m_fall[1], m_busy[1]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_strobe();
        test_fast();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
